// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and a wide occupancy carrier type
// used for threshold compares independent of the instance address width.
package fifo_pkg;

    localparam int CNT_MAX_W = 32;

    typedef logic [CNT_MAX_W-1:0] fifo_cnt_t;

    function automatic fifo_cnt_t bin2gray(input fifo_cnt_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic fifo_cnt_t gray2bin(input fifo_cnt_t g);
        fifo_cnt_t b;
        b = g;
        for (int i = 1; i < CNT_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: binary pointers with a wrap bit, registered flags derived from the
// next occupancy, sticky overflow/underflow and registered or fall-through read data.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  walmost_full,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int        DEPTH   = 1 << ADDR_WIDTH;
    localparam int        PW      = ADDR_WIDTH + 1;
    localparam fifo_cnt_t DEPTH_C = fifo_cnt_t'(DEPTH);
    localparam fifo_cnt_t AF_C    = fifo_cnt_t'(AFULL_THRESH);
    localparam fifo_cnt_t AE_C    = fifo_cnt_t'(AEMPTY_THRESH);

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_ctrl: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_aempty
        $error("sync_fifo_ctrl: AEMPTY_THRESH must be >= 0 and < AFULL_THRESH");
    end

    logic [PW-1:0]         r_wbin, r_rbin, r_count;
    logic [PW-1:0]         w_wbin_next, w_rbin_next, w_cnt_next;
    fifo_cnt_t             w_cnt_wide;
    logic                  r_wfull, r_rempty, r_afull, r_aempty, r_ovf, r_udf;
    logic                  w_wr_ok, w_rd_ok;
    logic [DATA_WIDTH-1:0] r_rdata, w_mem_rdata;

    // Accept decisions use only the registered flags, never the incoming request.
    assign w_wr_ok     = winc & ~r_wfull;
    assign w_rd_ok     = rinc & ~r_rempty;
    assign w_wbin_next = r_wbin + PW'(w_wr_ok);
    assign w_rbin_next = r_rbin + PW'(w_rd_ok);
    assign w_cnt_next  = w_wbin_next - w_rbin_next;
    assign w_cnt_wide  = fifo_cnt_t'(w_cnt_next);

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_wr_ok),
        .i_waddr(r_wbin[ADDR_WIDTH-1:0]),
        .i_wdata(wdata),
        .i_raddr(r_rbin[ADDR_WIDTH-1:0]),
        .o_rdata(w_mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbin   <= '0;
            r_rbin   <= '0;
            r_count  <= '0;
            r_rempty <= 1'b1;
            r_wfull  <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_rbin   <= w_rbin_next;
            r_count  <= w_cnt_next;
            r_rempty <= (w_cnt_wide == '0);
            r_wfull  <= (w_cnt_wide == DEPTH_C);
            r_afull  <= (w_cnt_wide >= AF_C);
            r_aempty <= (w_cnt_wide <= AE_C);
            // Set has priority over clear when both land in the same cycle.
            r_ovf    <= (winc & r_wfull)  | (r_ovf & ~clr_err);
            r_udf    <= (rinc & r_rempty) | (r_udf & ~clr_err);
            if (w_rd_ok) begin
                r_rdata <= w_mem_rdata;
            end
        end
    end

    // In fall-through mode r_rdata keeps the last popped word for display while empty.
    if (FWFT) begin : g_fwft
        assign rdata = r_rempty ? r_rdata : w_mem_rdata;
    end else begin : g_reg
        assign rdata = r_rdata;
    end

    assign wfull         = r_wfull;
    assign rempty        = r_rempty;
    assign walmost_full  = r_afull;
    assign ralmost_empty = r_aempty;
    assign count         = r_count;
    assign overflow      = r_ovf;
    assign underflow     = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a registered-read and a fall-through instance share one stimulus
// stream and are checked every cycle against a queue-based model plus literal spot checks.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata0, rdata1;
    logic       wfull0, rempty0, af0, ae0, ovf0, udf0;
    logic       wfull1, rempty1, af1, ae1, ovf1, udf1;
    logic [2:0] count0, count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
        .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .walmost_full(af0), .ralmost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
        .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(af1), .ralmost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(udf1)
    );

    // Behavioural model: a plain queue of words plus sticky error bits.
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0;
    logic [7:0] m_last = 8'h00;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_ovf  = 1'b0;
                m_udf  = 1'b0;
                m_last = 8'h00;
            end else begin
                bit full_b, empty_b;
                full_b  = (m_q.size() == 4);
                empty_b = (m_q.size() == 0);
                m_ovf = (winc && full_b)  || (m_ovf && !clr_err);
                m_udf = (rinc && empty_b) || (m_udf && !clr_err);
                if (rinc && !empty_b) m_last = m_q.pop_front();
                if (winc && !full_b) m_q.push_back(wdata);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            begin
                int n;
                logic [7:0] head;
                n    = m_q.size();
                head = (n != 0) ? m_q[0] : m_last;
                chk("count0", 32'(count0), 32'(n));
                chk("count1", 32'(count1), 32'(n));
                chk("rempty", {30'd0, rempty1, rempty0}, {30'd0, n == 0, n == 0});
                chk("wfull",  {30'd0, wfull1,  wfull0},  {30'd0, n == 4, n == 4});
                chk("afull",  {30'd0, af1, af0}, {30'd0, n >= 3, n >= 3});
                chk("aempty", {30'd0, ae1, ae0}, {30'd0, n <= 1, n <= 1});
                chk("ovf",    {30'd0, ovf1, ovf0}, {30'd0, m_ovf, m_ovf});
                chk("udf",    {30'd0, udf1, udf0}, {30'd0, m_udf, m_udf});
                chk("rdata_reg",  32'(rdata0), 32'(m_last));
                chk("rdata_fwft", 32'(rdata1), 32'(head));
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        winc = w; wdata = d; rinc = r; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rempty", 32'(rempty0), 32'd1);
        chk("rst_wfull",  32'(wfull0),  32'd0);
        chk("rst_count",  32'(count0),  32'd0);
        chk("rst_aempty", 32'(ae0),     32'd1);
        chk("rst_ovf_udf", {ovf0, udf0}, 32'd0);
        chk("rst_rdata",  32'(rdata0),  32'd0);

        // Fill to full, then overflow
        step(1, 8'hA1, 0, 0);
        step(1, 8'hA2, 0, 0);
        chk("af_at2", 32'(af0), 32'd0);
        step(1, 8'hA3, 0, 0);
        chk("af_at3", 32'(af0), 32'd1);
        step(1, 8'hA4, 0, 0);
        chk("full_at4", {wfull0, count0}, {28'd0, 1'b1, 3'd4});
        step(1, 8'hA5, 0, 0);
        chk("ovf_5th", {ovf0, count0}, {28'd0, 1'b1, 3'd4});

        // Drain with one extra read
        step(0, 8'h00, 1, 0); chk("rd1", 32'(rdata0), 32'hA1);
        step(0, 8'h00, 1, 0); chk("rd2", 32'(rdata0), 32'hA2);
        step(0, 8'h00, 1, 0); chk("rd3", 32'(rdata0), 32'hA3);
        step(0, 8'h00, 1, 0); chk("rd4", {rempty0, rdata0}, {23'd0, 1'b1, 8'hA4});
        step(0, 8'h00, 1, 0); chk("udf_5th", {udf0, rdata0}, {23'd0, 1'b1, 8'hA4});
        step(0, 8'h00, 0, 1); chk("clr_err", {ovf0, udf0}, 32'd0);

        // Interleaved traffic across two pointer wraps
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'h10 + i), i > 0, 0);
            if (i > 0) chk("wrap_rd", 32'(rdata0), 32'(8'h10 + i - 1));
        end

        // Simultaneous at count 2, then at full
        step(1, 8'h20, 0, 0);
        chk("cnt2", 32'(count0), 32'd2);
        step(1, 8'h21, 1, 0);
        chk("sim_cnt2", {count0, rdata0}, {21'd0, 3'd2, 8'h19});
        step(1, 8'h22, 0, 0);
        step(1, 8'h23, 0, 0);
        step(1, 8'h24, 1, 0);
        chk("sim_full", {ovf0, count0, rdata0}, {20'd0, 1'b1, 3'd3, 8'h20});
        step(0, 8'h00, 1, 1); chk("d21", 32'(rdata0), 32'h21);
        step(0, 8'h00, 1, 0); chk("d22", 32'(rdata0), 32'h22);
        step(0, 8'h00, 1, 0); chk("d23", 32'(rdata0), 32'h23);

        // Fall-through visibility without a pop
        step(1, 8'h5C, 0, 0);
        chk("fwft_vis", {rempty1, rdata1}, {23'd0, 1'b0, 8'h5C});
        step(0, 8'h00, 0, 0);
        chk("fwft_hold", 32'(rdata1), 32'h5C);
        step(0, 8'h00, 1, 0);
        chk("fwft_pop", {rempty1, rdata1}, {23'd0, 1'b1, 8'h5C});

        // Asynchronous reset mid-burst at count 3
        step(1, 8'h30, 0, 0);
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        chk("pre_rst_cnt", 32'(count0), 32'd3);
        winc = 1'b1; wdata = 8'h33;
        #2 rst = 1'b1;
        #1;
        chk("arst_count",  32'(count0), 32'd0);
        chk("arst_flags",  {rempty0, wfull0, af0, ae0}, {28'd0, 4'b1001});
        chk("arst_rdata",  {rdata0, rdata1}, 32'd0);
        winc = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 1, 0);
        chk("post_rst_rd", 32'(rdata0), 32'h77);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
